wbm_spi_ctrl: RTL and testbench

WBM_SPI_CTRL -- requirements
Module: wbm_spi_ctrl

---
 rtl/wbm_spi_pkg.sv | 22 ++
 rtl/wbm_spi_ctrl_sync2.sv | 22 ++
 rtl/wbm_spi_ctrl.sv | 125 ++++++++++++
 tb/tb_wbm_spi_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_spi_pkg.sv
// Shared definitions for the SPI-slave to Wishbone-master bridge:
// FSM state encoding, command byte layout and the timeout fill byte.
package wbm_spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_REL  = 3'd1,
        WDATA    = 3'd2,
        DATA_REL = 3'd3,
        BUS      = 3'd4,
        TX       = 3'd5,
        TX_REL   = 3'd6
    } state_t;

    // Command byte: [7] = write/not-read, [6:0] = Wishbone address.
    localparam int WE_BIT  = 7;
    localparam int ADR_MSB = 6;

    // Read data returned to the SPI host when the slave never acknowledges.
    localparam logic [7:0] TO_FILL = 8'hFF;

endpackage

// File: rtl/wbm_spi_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async level through two flops; reset clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wbm_spi_ctrl.sv
// SPI-slave byte stream to Wishbone classic master bridge.
// A command byte (and a data byte for writes) arrives over a four-phase
// handshake; one Wishbone cycle is run, and for reads the result is handed
// back to the SPI transmitter over a second four-phase handshake.
module wbm_spi_ctrl
    import wbm_spi_pkg::*;
#(
    parameter int TIMEOUT = 255   // must be >= 1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_ack,
    output logic       tx_req,
    output logic [7:0] tx_data,
    input  logic       tx_ack,
    output logic       wbm_cyc_o,
    output logic       wbm_stb_o,
    output logic       wbm_we_o,
    output logic [6:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    input  logic       wbm_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    // The counter holds k-1 during the k-th BUS cycle, so the edge that ends
    // cycle TIMEOUT is the one where it reaches TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_n;
    logic          rx_rdy_s, tx_ack_s;
    logic [7:0]    cmd;
    logic [CW-1:0] cnt;
    logic          timed_out;
    logic          ld_cmd, ld_wdat, bus_entry, cap_rd;

    sync2 u_sync_rx (.clk(wb_clk_i), .rst(wb_rst_i), .d(rx_rdy), .q(rx_rdy_s));
    sync2 u_sync_tx (.clk(wb_clk_i), .rst(wb_rst_i), .d(tx_ack), .q(tx_ack_s));

    assign timed_out = (cnt >= CNT_LAST);

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_n;
    end

    // Next state and datapath load strobes; ack wins over timeout in BUS.
    always_comb begin
        state_n   = state;
        ld_cmd    = 1'b0;
        ld_wdat   = 1'b0;
        bus_entry = 1'b0;
        cap_rd    = 1'b0;
        case (state)
            IDLE: if (rx_rdy_s) begin
                ld_cmd  = 1'b1;
                state_n = CMD_REL;
            end
            CMD_REL: if (!rx_rdy_s) begin
                if (cmd[WE_BIT]) begin
                    state_n = WDATA;
                end else begin
                    state_n   = BUS;
                    bus_entry = 1'b1;
                end
            end
            WDATA: if (rx_rdy_s) begin
                ld_wdat = 1'b1;
                state_n = DATA_REL;
            end
            DATA_REL: if (!rx_rdy_s) begin
                state_n   = BUS;
                bus_entry = 1'b1;
            end
            BUS: if (wbm_ack_i || timed_out) begin
                if (cmd[WE_BIT]) begin
                    state_n = IDLE;
                end else begin
                    state_n = TX;
                    cap_rd  = 1'b1;
                end
            end
            TX:      if (tx_ack_s)  state_n = TX_REL;
            TX_REL:  if (!tx_ack_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs follow the next state so they are valid from the
    // first cycle of each state; data registers load on the strobes above.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_ack    <= 1'b0;
            tx_req    <= 1'b0;
            tx_data   <= 8'h00;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 7'h00;
            wbm_dat_o <= 8'h00;
            cmd       <= 8'h00;
            cnt       <= '0;
        end else begin
            rx_ack    <= (state_n == CMD_REL) || (state_n == DATA_REL);
            tx_req    <= (state_n == TX);
            wbm_cyc_o <= (state_n == BUS);
            wbm_stb_o <= (state_n == BUS);
            wbm_we_o  <= (state_n == BUS) ? cmd[WE_BIT] : 1'b0;
            if (ld_cmd)  cmd       <= rx_data;
            if (ld_wdat) wbm_dat_o <= rx_data;
            if (bus_entry) begin
                wbm_adr_o <= cmd[ADR_MSB:0];
                cnt       <= '0;
            end else if (state == BUS && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (cap_rd) tx_data <= wbm_ack_i ? wbm_dat_i : TO_FILL;
        end
    end

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// Bench for wbm_spi_ctrl: SPI-side driver, Wishbone slave with scripted ack
// latency, SPI transmitter responder, and a transaction-level model that
// predicts every bus cycle and every byte returned to the host.
module tb_wbm_spi_ctrl;

    localparam int TIMEOUT = 4;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ack;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack = 1'b0;
    logic       wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [6:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i = 8'h00;
    logic       wbm_ack_i = 1'b0;

    wbm_spi_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_ack(rx_ack),
        .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic       we;
        logic [6:0] adr;
        logic [7:0] wdat;
        int         lat;    // BUS cycle in which the slave acks; 0 = never
        logic [7:0] rdat;
    } txn_t;

    txn_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cur_lat = 0;
    logic [7:0] cur_rdat = 8'h00;
    logic       mon_en = 1'b0;
    logic [7:0] tx_model = 8'h00;
    bit         tx_pend = 1'b0;
    int         tx_rises = 0;
    logic [6:0] last_adr = 7'h00;
    logic       last_we = 1'b0;
    logic [7:0] last_dat = 8'h00;
    int         last_len = 0;
    logic [7:0] last_tx_seen = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic bound_chk(input string name, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: wait bound expired", name);
        end
    endtask

    // Wishbone slave: ack in the cur_lat-th cycle of the bus cycle.
    int s_cnt = 0;
    always @(negedge wb_clk_i) begin
        if (wbm_cyc_o === 1'b1) begin
            s_cnt++;
            wbm_ack_i = (cur_lat != 0 && s_cnt == cur_lat);
            wbm_dat_i = wbm_ack_i ? cur_rdat : 8'($urandom);
        end else begin
            s_cnt     = 0;
            wbm_ack_i = 1'b0;
            wbm_dat_i = 8'($urandom);
        end
    end

    // SPI transmitter: acknowledge each tx_req after a random delay.
    initial begin
        forever begin
            @(posedge wb_clk_i) #1;
            if (tx_req === 1'b1) begin
                repeat ($urandom_range(4, 8)) @(posedge wb_clk_i) #1;
                tx_ack = 1'b1;
                for (int i = 0; i < 60 && tx_req !== 1'b0; i++) @(posedge wb_clk_i) #1;
                bound_chk("tx_req_fall", tx_req === 1'b0);
                repeat ($urandom_range(1, 3)) @(posedge wb_clk_i) #1;
                tx_ack = 1'b0;
            end
        end
    end

    // Compare process: every cycle, outputs against the transaction model.
    int   run = 0;
    txn_t cur_t;
    bit   cur_ok = 1'b0;
    logic prev_tx_req = 1'b0;
    always @(negedge wb_clk_i) begin
        if (!mon_en || wb_rst_i) begin
            run         = 0;
            prev_tx_req = 1'b0;
        end else begin
            if (wbm_cyc_o === 1'b1) begin
                if (run == 0) begin
                    cur_ok = (exp_q.size() != 0);
                    bound_chk("bus_expected", cur_ok);
                    if (cur_ok) cur_t = exp_q[0];
                end
                run++;
                chk("stb_in_bus", 32'(wbm_stb_o), 32'h1);
                if (cur_ok) begin
                    chk("we", 32'(wbm_we_o), 32'(cur_t.we));
                    chk("adr", 32'(wbm_adr_o), 32'(cur_t.adr));
                    if (cur_t.we) chk("dat_o", 32'(wbm_dat_o), 32'(cur_t.wdat));
                end
                last_adr = wbm_adr_o;
                last_we  = wbm_we_o;
                last_dat = wbm_dat_o;
            end else begin
                if (run != 0 && cur_ok) begin
                    bit acked;
                    acked = (cur_t.lat != 0 && cur_t.lat <= TIMEOUT);
                    chk("bus_len", 32'(run), acked ? 32'(cur_t.lat) : 32'(TIMEOUT));
                    if (!cur_t.we) begin
                        tx_model = acked ? cur_t.rdat : 8'hFF;
                        tx_pend  = 1'b1;
                    end
                    void'(exp_q.pop_front());
                end
                if (run != 0) last_len = run;
                run = 0;
                chk("stb_idle", 32'(wbm_stb_o), 32'h0);
            end
            chk("tx_data", 32'(tx_data), 32'(tx_model));
            if (wbm_cyc_o === 1'b1 || tx_req === 1'b1)
                chk("rx_ack_busy", 32'(rx_ack), 32'h0);
            if (tx_req === 1'b1 && prev_tx_req !== 1'b1) begin
                chk("tx_req_pending", 32'(tx_pend), 32'h1);
                tx_pend      = 1'b0;
                tx_rises++;
                last_tx_seen = tx_data;
            end
            prev_tx_req = tx_req;
        end
    end

    // Four-phase delivery of one byte to the DUT receiver side.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 80 && rx_ack !== 1'b1; i++) @(posedge wb_clk_i) #1;
        bound_chk("rx_ack_rise", rx_ack === 1'b1);
        repeat ($urandom_range(0, 2)) @(posedge wb_clk_i) #1;
        rx_rdy  = 1'b0;
        rx_data = 8'($urandom);
        for (int i = 0; i < 80 && rx_ack !== 1'b0; i++) @(posedge wb_clk_i) #1;
        bound_chk("rx_ack_fall", rx_ack === 1'b0);
    endtask

    // One full transaction; spur injects rx_rdy pulses while busy.
    task automatic do_txn(input logic we, input logic [6:0] adr, input logic [7:0] wdat,
                          input int lat, input logic [7:0] rdat, input bit spur);
        txn_t t;
        t.we = we; t.adr = adr; t.wdat = wdat; t.lat = lat; t.rdat = rdat;
        exp_q.push_back(t);
        cur_lat  = lat;
        cur_rdat = rdat;
        send_byte({we, adr});
        if (we) send_byte(wdat);
        if (spur && (lat == 0 || lat >= TIMEOUT)) begin
            for (int i = 0; i < 20 && wbm_cyc_o !== 1'b1; i++) @(posedge wb_clk_i) #1;
            rx_data = 8'($urandom);
            rx_rdy  = 1'b1;
            @(posedge wb_clk_i) #1;
            rx_rdy  = 1'b0;
        end
        if (spur && !we) begin
            for (int i = 0; i < 60 && tx_req !== 1'b1; i++) @(posedge wb_clk_i) #1;
            bound_chk("spur_tx_req", tx_req === 1'b1);
            rx_data = 8'($urandom);
            rx_rdy  = 1'b1;
            @(posedge wb_clk_i) #1;
            rx_rdy  = 1'b0;
        end
        for (int i = 0; i < 200 && !(exp_q.size() == 0 && !tx_pend && tx_req === 1'b0 && tx_ack === 1'b0); i++)
            @(posedge wb_clk_i) #1;
        bound_chk("txn_done", exp_q.size() == 0 && !tx_pend && tx_req === 1'b0 && tx_ack === 1'b0);
        repeat (2) @(posedge wb_clk_i) #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("rst_rx_ack", 32'(rx_ack), 32'h0);
        chk("rst_tx_req", 32'(tx_req), 32'h0);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'h0);
        chk("rst_stb", 32'(wbm_stb_o), 32'h0);
        chk("rst_we", 32'(wbm_we_o), 32'h0);
        chk("rst_adr", 32'(wbm_adr_o), 32'h0);
        chk("rst_dat_o", 32'(wbm_dat_o), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        @(posedge wb_clk_i) #1;
        mon_en = 1'b1;

        // Write 8'h85, 8'h3C.
        r0 = tx_rises;
        do_txn(1'b1, 7'h05, 8'h3C, 2, 8'h00, 1'b0);
        chk("w_adr", 32'(last_adr), 32'h05);
        chk("w_we", 32'(last_we), 32'h1);
        chk("w_dat", 32'(last_dat), 32'h3C);
        chk("w_len", 32'(last_len), 32'd2);
        chk("w_no_tx_req", 32'(tx_rises), 32'(r0));

        // Read 8'h12, ack after 3 cycles with 8'hA7.
        do_txn(1'b0, 7'h12, 8'h00, 3, 8'hA7, 1'b0);
        chk("r_adr", 32'(last_adr), 32'h12);
        chk("r_we", 32'(last_we), 32'h0);
        chk("r_len", 32'(last_len), 32'd3);
        chk("r_tx", 32'(last_tx_seen), 32'hA7);

        // Timeout on read 8'h01.
        do_txn(1'b0, 7'h01, 8'h00, 0, 8'h00, 1'b0);
        chk("to_len", 32'(last_len), 32'd4);
        chk("to_tx", 32'(last_tx_seen), 32'hFF);

        // Ack in the TIMEOUT-th cycle wins.
        do_txn(1'b0, 7'h01, 8'h00, TIMEOUT, 8'h55, 1'b0);
        chk("edge_len", 32'(last_len), 32'd4);
        chk("edge_tx", 32'(last_tx_seen), 32'h55);

        // Spurious rx_rdy while busy.
        do_txn(1'b0, 7'h2A, 8'h00, 0, 8'h99, 1'b1);
        chk("spur_to_tx", 32'(last_tx_seen), 32'hFF);
        do_txn(1'b1, 7'h44, 8'hC3, 5, 8'h00, 1'b1);
        chk("spur_w_dat", 32'(last_dat), 32'hC3);
        do_txn(1'b0, 7'h10, 8'h00, 2, 8'h6E, 1'b1);
        chk("spur_r_tx", 32'(last_tx_seen), 32'h6E);

        // Reset in the middle of a write bus cycle.
        mon_en  = 1'b0;
        cur_lat = 0;
        send_byte(8'h9A);
        send_byte(8'h11);
        for (int i = 0; i < 20 && wbm_cyc_o !== 1'b1; i++) @(posedge wb_clk_i) #1;
        bound_chk("rst_bus_seen", wbm_cyc_o === 1'b1);
        @(posedge wb_clk_i) #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i) #1;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("midrst_cyc", 32'(wbm_cyc_o), 32'h0);
        chk("midrst_stb", 32'(wbm_stb_o), 32'h0);
        chk("midrst_rx_ack", 32'(rx_ack), 32'h0);
        chk("midrst_tx_data", 32'(tx_data), 32'h0);
        @(posedge wb_clk_i) #1;
        exp_q.delete();
        tx_model = 8'h00;
        tx_pend  = 1'b0;
        mon_en   = 1'b1;
        do_txn(1'b0, 7'h02, 8'h00, 2, 8'h5A, 1'b0);
        chk("postrst_adr", 32'(last_adr), 32'h02);
        chk("postrst_tx", 32'(last_tx_seen), 32'h5A);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            logic       we;
            logic [6:0] adr;
            logic [7:0] wdat, rdat;
            int         lat;
            bit         spur;
            we   = 1'($urandom_range(0, 1));
            adr  = 7'($urandom);
            wdat = 8'($urandom);
            rdat = 8'($urandom);
            lat  = $urandom_range(0, 6);
            spur = ($urandom_range(0, 3) == 0);
            do_txn(we, adr, wdat, lat, rdat, spur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
